// File: rtl/mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch (I) and data (D) sides.
// D has priority; a one-deep Starve flag guarantees the next grant to a waiting fetch.
module mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IReq,
    input  logic [15:0] IAddr,
    output logic        IStall,
    output logic        IDone,
    output logic [15:0] IData,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic        DDump,
    input  logic [15:0] DAddr,
    input  logic [15:0] DWriteData,
    output logic        DStall,
    output logic        DDone,
    output logic [15:0] DData,
    output logic        Err,
    output logic        MemEn,
    output logic        MemWr,
    output logic        MemDump,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

    localparam logic [2:0] LAT = 3'(LATENCY);

    state_t      state, stateNext;
    logic [2:0]  cnt, cntNext;
    logic        starve, starveNext;
    logic [15:0] capAddr, capData;
    logic        capWr, capDump;
    logic        grantI, grantD, atEnd;

    // Handshake: a requester raises xReq with stable fields and holds it until the
    // one-cycle xDone pulse; fields are sampled only at the grant edge, and
    // xStall = xReq & ~xDone tells the pipeline stage to hold meanwhile.
    assign grantI = (state == IDLE) && IReq && (starve || !DReq);
    assign grantD = (state == IDLE) && DReq && !grantI;
    assign atEnd  = (state != IDLE) && (cnt == LAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            starve  <= 1'b0;
            capAddr <= 16'h0000;
            capData <= 16'h0000;
            capWr   <= 1'b0;
            capDump <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            starve <= starveNext;
            if (grantI || grantD) begin
                capAddr <= grantI ? IAddr : DAddr;
                capData <= grantD ? DWriteData : 16'h0000;
                capWr   <= grantD && DWrite;
                capDump <= grantD && DDump;
            end
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        starveNext = starve;
        case (state)
            IDLE: begin
                if (grantI) begin
                    stateNext  = IBUSY;
                    cntNext    = 3'd0;
                    starveNext = 1'b0;
                end else if (grantD) begin
                    stateNext = DBUSY;
                    cntNext   = 3'd0;
                    // Fetch was refused this cycle, so it owns the next grant.
                    if (IReq) starveNext = 1'b1;
                end
            end
            default: begin
                if (atEnd) begin
                    stateNext = IDLE;
                    cntNext   = 3'd0;
                end else begin
                    cntNext = cnt + 3'd1;
                end
            end
        endcase
    end

    assign MemEn     = (state != IDLE) && (cnt == 3'd0);
    assign MemWr     = MemEn && capWr;
    assign MemDump   = MemEn && capDump;
    assign MemAddr   = capAddr;
    assign MemDataIn = capData;

    assign IDone  = atEnd && (state == IBUSY);
    assign DDone  = atEnd && (state == DBUSY);
    assign IData  = IDone ? MemDataOut : 16'h0000;
    assign DData  = DDone ? MemDataOut : 16'h0000;
    assign Err    = atEnd && capAddr[0];
    assign IStall = IReq && !IDone;
    assign DStall = DReq && !DDone;

    assign dbgState = state;

endmodule
